multi_key_debouncer: RTL and testbench
======================================

MULTI_KEY_DEBOUNCER -- requirements
Module: multi_key_debouncer

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- CODE_W, 4: key code width.
- DEBOUNCE_CYCLES, 12: stable cycles required to accept a press or release; must be >= 1.
- CNT_W, 20: width of the debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).
- REPEAT_EN, 0: 1 enables auto-repeat.
- REPEAT_DELAY, 40: cycles in HELD before the first repeat pulse; must be >= 1.
- REPEAT_PERIOD, 16: cycles between later repeat pulses; must be >= 1.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1: sole clock; all state is updated on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- key_pressed, in, 1: raw "some key down" indication from the scanner.
- key_code, in, CODE_W: raw code of the pressed key.
- code_out, out, CODE_W: last accepted key code.
- press_pulse, out, 1: one-cycle strobe when a press is accepted.
- release_pulse, out, 1: one-cycle strobe when a release is accepted.
- repeat_pulse, out, 1: one-cycle auto-repeat strobe.
- held, out, 1: high while the FSM is in HELD or DB_RELEASE.

Function
REQ-003 The FSM SHALL have four states: IDLE, DB_PRESS, HELD, DB_RELEASE.
REQ-004 The debounce counter cnt SHALL be CNT_W bits wide. Its terminal value SHALL be DEBOUNCE_CYCLES-1.
REQ-005 In IDLE with key_pressed=1, the block SHALL go to DB_PRESS, set cnt to 0 and capture key_code into the candidate register cand.
REQ-006 In DB_PRESS with key_pressed=0, the block SHALL abort to IDLE on that edge, clear cnt and assert no pulse.
REQ-007 In DB_PRESS with key_pressed=1 and key_code != cand, it SHALL load cand with key_code, clear cnt and stay in DB_PRESS (code-stability restart).
REQ-008 In DB_PRESS with key_pressed=1, key_code == cand and cnt at terminal, it SHALL go to HELD and load code_out from cand. Otherwise it SHALL increment cnt.
REQ-009 press_pulse SHALL be registered and high exactly during the first cycle in HELD after entry from DB_PRESS. Total latency from the first edge sampling a stable press SHALL be DEBOUNCE_CYCLES+1 edges.
REQ-010 In HELD with key_pressed=0, the block SHALL go to DB_RELEASE and clear cnt. key_code changes while in HELD SHALL be ignored.
REQ-011 In DB_RELEASE with key_pressed=1, the block SHALL return to HELD, clear cnt and assert no pulse. In this case rcnt SHALL be preserved, not cleared.
REQ-012 In DB_RELEASE with key_pressed=0 and cnt at terminal, it SHALL go to IDLE with release_pulse high during the first IDLE cycle. Otherwise it SHALL increment cnt.
REQ-013 code_out SHALL change only on acceptance per REQ-008. It SHALL retain its value through release and IDLE.
REQ-014 With REPEAT_EN=1, the repeat counter rcnt SHALL be cleared on entry to HELD from DB_PRESS and SHALL count every cycle in HELD, saturating rather than wrapping.
REQ-015 repeat_pulse SHALL fire for one cycle when rcnt reaches REPEAT_DELAY, and then every REPEAT_PERIOD cycles while in HELD. It SHALL never fire in the same cycle as press_pulse.
REQ-016 rcnt SHALL freeze in DB_RELEASE, and no repeat_pulse SHALL fire in DB_RELEASE.
REQ-017 With REPEAT_EN=0, repeat_pulse SHALL be constant 0 and the rcnt logic SHALL be removed.
REQ-018 With DEBOUNCE_CYCLES=1, acceptance SHALL occur on the edge after entry to DB_PRESS, and the same SHALL hold for DB_RELEASE.
REQ-019 Illegal state encodings SHALL recover to IDLE on the next edge with all strobes low.

Reset
REQ-020 reset=1 SHALL immediately, without waiting for clk, force: state IDLE, cnt=0, rcnt=0, cand=0, code_out all ones, press_pulse=0, release_pulse=0, repeat_pulse=0, held=0.
REQ-021 Reset asserted in the middle of any state SHALL discard any pending press or release with no strobe. Normal operation SHALL resume on the first edge after deassertion.

Verification
REQ-022 Clean press: key_pressed=1 and key_code=4'h5 held for 30 cycles, then released for 30 cycles (defaults) -> press_pulse exactly one cycle, 13 edges after the first sample; code_out=5; release_pulse exactly one cycle, 13 edges after the drop; held high between them.
REQ-023 Bounce: key_pressed toggles every 3 cycles for 40 cycles, then returns to 0 -> no press, release or repeat pulses; code_out stays 4'hF.
REQ-024 Code glitch: key_code=4'h3 for 6 cycles, then 4'h7 stable, with key_pressed=1 throughout -> press_pulse 13 edges after the switch to 7; code_out=7.
REQ-025 Release bounce: in HELD, key_pressed drops for 5 cycles, then rises again -> no release_pulse, held stays high, code_out unchanged.
REQ-026 Repeat: REPEAT_EN=1, REPEAT_DELAY=20, REPEAT_PERIOD=8, key held for 60 cycles after acceptance -> repeat_pulse at 20, 28, 36, 44 and 52 cycles after press_pulse, then stops on release.
REQ-027 Async reset: assert reset mid-DB_PRESS, between clock edges -> outputs take their reset values before the next edge; no press_pulse after deassertion unless a full debounce completes.

Source files
------------

// File: rtl/multi_key_debouncer.sv
// Debounces a scanned "key down" flag and its key code, and emits press, release
// and optional auto-repeat strobes.
module multi_key_debouncer #(
   parameter int CODE_W          = 4,
   parameter int DEBOUNCE_CYCLES = 12,
   parameter int CNT_W           = 20,
   parameter int REPEAT_EN       = 0,
   parameter int REPEAT_DELAY    = 40,
   parameter int REPEAT_PERIOD   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              key_pressed,
   input  logic [CODE_W-1:0] key_code,
   output logic [CODE_W-1:0] code_out,
   output logic              press_pulse,
   output logic              release_pulse,
   output logic              repeat_pulse,
   output logic              held
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      HELD       = 2'd2,
      DB_RELEASE = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [CODE_W-1:0]   cand_reg, cand_next;
   logic [CODE_W-1:0]   code_reg, code_next;
   logic                press_reg, press_next;
   logic                release_reg, release_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         cand_reg    <= '0;
         code_reg    <= '1;
         press_reg   <= 1'b0;
         release_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         cand_reg    <= cand_next;
         code_reg    <= code_next;
         press_reg   <= press_next;
         release_reg <= release_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      cand_next    = cand_reg;
      code_next    = code_reg;
      press_next   = 1'b0;
      release_next = 1'b0;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (key_pressed) begin
               state_next = DB_PRESS;
               cand_next  = key_code;
            end
         end
         DB_PRESS: begin
            if (!key_pressed) begin
               state_next = IDLE;
               cnt_next   = '0;
            end else if (key_code != cand_reg) begin
               // a changing code restarts the stability window
               cand_next = key_code;
               cnt_next  = '0;
            end else if (cnt_reg == CNT_TERM) begin
               state_next = HELD;
               cnt_next   = '0;
               code_next  = cand_reg;
               press_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         HELD: begin
            if (!key_pressed) begin
               state_next = DB_RELEASE;
               cnt_next   = '0;
            end
         end
         DB_RELEASE: begin
            if (key_pressed) begin
               state_next = HELD;
               cnt_next   = '0;
            end else if (cnt_reg == CNT_TERM) begin
               state_next   = IDLE;
               cnt_next     = '0;
               release_next = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   generate
      if (REPEAT_EN != 0) begin : g_repeat
         localparam logic [CNT_W-1:0] DELAY    = CNT_W'(REPEAT_DELAY);
         localparam logic [CNT_W-1:0] PER_TERM = CNT_W'(REPEAT_PERIOD - 1);

         logic [CNT_W-1:0] rcnt_reg, rcnt_next, rcnt_inc;
         logic [CNT_W-1:0] pcnt_reg, pcnt_next;
         logic             repeat_reg, repeat_next;
         logic             past_delay;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               rcnt_reg   <= '0;
               pcnt_reg   <= '0;
               repeat_reg <= 1'b0;
            end else begin
               rcnt_reg   <= rcnt_next;
               pcnt_reg   <= pcnt_next;
               repeat_reg <= repeat_next;
            end
         end

         // rcnt measures time held; pcnt tracks phase within the repeat period
         always_comb begin
            rcnt_next   = rcnt_reg;
            pcnt_next   = pcnt_reg;
            repeat_next = 1'b0;
            rcnt_inc    = (rcnt_reg == '1) ? rcnt_reg : rcnt_reg + 1'b1;
            past_delay  = (rcnt_reg >= DELAY);
            if (press_next) begin
               rcnt_next = '0;
               pcnt_next = '0;
            end else if (state_reg == HELD && key_pressed) begin
               // a cycle leaving HELD is not counted so no strobe lands in DB_RELEASE
               rcnt_next = rcnt_inc;
               if (past_delay ? (pcnt_reg == PER_TERM) : (rcnt_inc == DELAY)) begin
                  repeat_next = 1'b1;
                  pcnt_next   = '0;
               end else if (past_delay) begin
                  pcnt_next = pcnt_reg + 1'b1;
               end
            end
         end

         assign repeat_pulse = repeat_reg;
      end else begin : g_no_repeat
         assign repeat_pulse = 1'b0;
      end
   endgenerate

   assign code_out      = code_reg;
   assign press_pulse   = press_reg;
   assign release_pulse = release_reg;
   assign held          = (state_reg == HELD) || (state_reg == DB_RELEASE);

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Scoreboard bench: stimulus queues expected strobes, a negedge monitor pops and checks them.
module tb_multi_key_debouncer;

   localparam int KP = 0, KR = 1, KT = 2;

   typedef struct {
      int         kind;
      int         at;
      logic [3:0] code;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       kp, kp2;
   logic [3:0] kc, kc2;
   logic [3:0] code0, code1;
   logic       pr0, rl0, rp0, hd0;
   logic       pr1, rl1, rp1, hd1;

   int  cyc = 0;
   int  n_vec = 0;
   int  n_miss = 0;
   ev_t q0[$];
   ev_t q1[$];

   multi_key_debouncer dut (
      .clk(clk), .reset(reset), .key_pressed(kp), .key_code(kc),
      .code_out(code0), .press_pulse(pr0), .release_pulse(rl0),
      .repeat_pulse(rp0), .held(hd0)
   );

   multi_key_debouncer #(.REPEAT_EN(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut_rep (
      .clk(clk), .reset(reset), .key_pressed(kp2), .key_code(kc2),
      .code_out(code1), .press_pulse(pr1), .release_pulse(rl1),
      .repeat_pulse(rp1), .held(hd1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_ev(input int which, input int kind, input int at, input logic [3:0] code);
      ev_t e;
      e.kind = kind;
      e.at   = at;
      e.code = code;
      if (which == 0) q0.push_back(e);
      else            q1.push_back(e);
   endtask

   task automatic see_ev(input int which, input int kind, input logic [3:0] code);
      ev_t e;
      if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
         n_vec++;
         n_miss++;
         $display("FAIL unexpected strobe: dut%0d kind %0d at cycle %0d, required none", which, kind, cyc);
      end else begin
         if (which == 0) e = q0.pop_front();
         else            e = q1.pop_front();
         $display("dut%0d strobe kind %0d code %0h at cycle %0d (expected kind %0d at %0d)",
                  which, kind, code, cyc, e.kind, e.at);
         chk("strobe kind", kind, e.kind);
         chk("strobe cycle", cyc, e.at);
         chk("strobe code", {28'd0, code}, {28'd0, e.code});
      end
   endtask

   always @(negedge clk) begin
      if (pr0) see_ev(0, KP, code0);
      if (rl0) see_ev(0, KR, code0);
      if (rp0) see_ev(0, KT, code0);
      if (pr1) see_ev(1, KP, code1);
      if (rl1) see_ev(1, KR, code1);
      if (rp1) see_ev(1, KT, code1);
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int x, p;
      reset = 1'b1;
      kp = 1'b0; kc = 4'h0; kp2 = 1'b0; kc2 = 4'h0;
      wait_cyc(2);
      chk("reset code_out", {28'd0, code0}, 32'hF);
      chk("reset held", {31'd0, hd0}, 32'd0);
      chk("reset strobes", {29'd0, pr0, rl0, rp0}, 32'd0);
      chk("reset code_out rep", {28'd0, code1}, 32'hF);
      reset = 1'b0;
      wait_cyc(3);

      // bounce: never stable long enough
      for (int i = 0; i < 40; i++) begin
         kp = ((i / 3) % 2 == 0);
         kc = 4'h5;
         @(negedge clk);
      end
      kp = 1'b0;
      wait_cyc(20);
      chk("bounce code_out", {28'd0, code0}, 32'hF);
      chk("bounce held", {31'd0, hd0}, 32'd0);

      // clean press and release
      x = cyc; kp = 1'b1; kc = 4'h5;
      expect_ev(0, KP, x + 13, 4'h5);
      wait_cyc(12);
      chk("held before accept", {31'd0, hd0}, 32'd0);
      wait_cyc(1);
      chk("held at accept", {31'd0, hd0}, 32'd1);
      chk("code_out at accept", {28'd0, code0}, 32'h5);
      wait_cyc(17);
      x = cyc; kp = 1'b0;
      expect_ev(0, KR, x + 13, 4'h5);
      wait_cyc(12);
      chk("held in db_release", {31'd0, hd0}, 32'd1);
      wait_cyc(1);
      chk("held after release", {31'd0, hd0}, 32'd0);
      chk("code_out retained", {28'd0, code0}, 32'h5);
      wait_cyc(17);

      // code glitch restarts debounce
      kp = 1'b1; kc = 4'h3;
      wait_cyc(6);
      x = cyc; kc = 4'h7;
      expect_ev(0, KP, x + 13, 4'h7);
      wait_cyc(13);
      chk("glitch code_out", {28'd0, code0}, 32'h7);
      kc = 4'h2;
      wait_cyc(5);

      // release bounce in HELD
      kp = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("release bounce held", {31'd0, hd0}, 32'd1);
      end
      kp = 1'b1;
      wait_cyc(20);
      chk("release bounce held end", {31'd0, hd0}, 32'd1);
      chk("code ignored in HELD", {28'd0, code0}, 32'h7);
      x = cyc; kp = 1'b0;
      expect_ev(0, KR, x + 13, 4'h7);
      wait_cyc(20);

      // one sample short of acceptance
      kp = 1'b1; kc = 4'hC;
      wait_cyc(12);
      kp = 1'b0;
      wait_cyc(20);
      chk("short press code_out", {28'd0, code0}, 32'h7);
      chk("short press held", {31'd0, hd0}, 32'd0);

      // exactly enough samples, immediate release
      x = cyc; kp = 1'b1; kc = 4'hC;
      expect_ev(0, KP, x + 13, 4'hC);
      expect_ev(0, KR, x + 26, 4'hC);
      wait_cyc(13);
      kp = 1'b0;
      wait_cyc(20);
      chk("exact press code_out", {28'd0, code0}, 32'hC);

      // async reset between edges, mid DB_PRESS
      kp = 1'b1; kc = 4'h9;
      wait_cyc(5);
      #2 reset = 1'b1;
      #1;
      chk("async reset code_out", {28'd0, code0}, 32'hF);
      chk("async reset held", {31'd0, hd0}, 32'd0);
      chk("async reset strobes", {29'd0, pr0, rl0, rp0}, 32'd0);
      wait_cyc(3);
      reset = 1'b0;
      x = cyc;
      expect_ev(0, KP, x + 13, 4'h9);
      wait_cyc(13);
      chk("post reset code_out", {28'd0, code0}, 32'h9);
      x = cyc; kp = 1'b0;
      expect_ev(0, KR, x + 13, 4'h9);
      wait_cyc(20);

      // auto-repeat on the second instance
      x = cyc; kp2 = 1'b1; kc2 = 4'hA;
      p = x + 13;
      expect_ev(1, KP, p, 4'hA);
      expect_ev(1, KT, p + 20, 4'hA);
      expect_ev(1, KT, p + 28, 4'hA);
      expect_ev(1, KT, p + 36, 4'hA);
      expect_ev(1, KT, p + 44, 4'hA);
      expect_ev(1, KT, p + 52, 4'hA);
      wait_cyc(p + 59 - cyc);
      kp2 = 1'b0;
      expect_ev(1, KR, p + 72, 4'hA);
      wait_cyc(13);
      chk("repeat held after release", {31'd0, hd1}, 32'd0);
      wait_cyc(10);

      chk("dut queue drained", q0.size(), 32'd0);
      chk("dut_rep queue drained", q1.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
